// File: rtl/demux4_deser_if.sv
// ---------------------------------------------------------------------------
// demux4_deser_if
// Bundles the bit-level input side and the word-level output side of
// demux4_deser into a single interface.
//
// Build option: define DEMUX_DESER_PARITY_EN to add the word_par signal.
//
// Signals
//   bit_valid  : a valid bit is present on ch_in/sel this cycle
//   sel[1:0]   : channel currently routed by the upstream demux
//   ch_in[3:0] : demux outputs; only ch_in[sel] is meaningful
//   word_ready : downstream accepts the presented word this cycle
//   ovf_clr    : synchronous clear of all sticky overflow flags
//   word_valid : word_data/word_ch hold a valid word
//   word_data  : assembled word (MSB received first)
//   word_ch    : channel the presented word came from
//   overflow   : sticky per-channel overflow flags
//   word_par   : (optional) XOR reduction of word_data
//
// Modports
//   master : the side that feeds bits and consumes words (testbench/system)
//   slave  : the deserializer itself
// ---------------------------------------------------------------------------
interface demux4_deser_if #(
    parameter int WORD_W = 8
);
    logic              bit_valid;
    logic [1:0]        sel;
    logic [3:0]        ch_in;
    logic              word_ready;
    logic              ovf_clr;
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic [1:0]        word_ch;
    logic [3:0]        overflow;
`ifdef DEMUX_DESER_PARITY_EN
    logic              word_par;
`endif

    modport master (
        output bit_valid, sel, ch_in, word_ready, ovf_clr,
        input  word_valid, word_data, word_ch, overflow
`ifdef DEMUX_DESER_PARITY_EN
        , input word_par
`endif
    );

    modport slave (
        input  bit_valid, sel, ch_in, word_ready, ovf_clr,
        output word_valid, word_data, word_ch, overflow
`ifdef DEMUX_DESER_PARITY_EN
        , output word_par
`endif
    );
endinterface

// File: rtl/demux4_deser.sv
// ---------------------------------------------------------------------------
// demux4_deser
// Samples the outputs of a 1:4 bit demultiplexer, deserializes each of the
// four channels independently into WORD_W-bit words (MSB first) and drains
// completed words through a single valid/ready port using a round-robin
// arbiter.
//
// Build option: define DEMUX_DESER_PARITY_EN to add bus.word_par, the even
// parity (XOR reduction) of word_data, registered alongside it.
//
// Ports
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : demux4_deser_if.slave (bit input side + word output side)
//
// Parameter
//   WORD_W : bits per assembled word, 2..32
// ---------------------------------------------------------------------------
module demux4_deser #(
    parameter int WORD_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    demux4_deser_if.slave  bus
);
    localparam int CW = (WORD_W > 2) ? $clog2(WORD_W) : 1;

    // Only WORD_W-1 bits need storing: the final bit is appended on the fly
    // at the completing edge.
    logic [WORD_W-2:0] shreg_q [4];
    logic [CW-1:0]     cnt_q   [4];
    logic [WORD_W-1:0] hold_q  [4];
    logic [3:0]        pend_q, pend_d;
    logic [3:0]        ovf_q, ovf_d;
    logic [1:0]        ptr_q, ptr_d;

    logic              valid_q, valid_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [1:0]        ch_q, ch_d;
`ifdef DEMUX_DESER_PARITY_EN
    logic              par_q, par_d;
`endif

    logic [3:0]        cap, done, drain, accept, ovf_set;
    logic [WORD_W-1:0] word_new [4];

    logic              load;
    logic              grant_vld;
    logic [1:0]        grant_idx;
    logic [1:0]        idx;

    // Output register may take a new word when empty or when the current one
    // is leaving this edge.
    assign load = !valid_q || bus.word_ready;

    // Round-robin search starting at ptr_q. Iterating from the farthest
    // offset down lets the nearest pending channel win.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = ptr_q;
        idx       = '0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr_q + 2'(i);
            if (pend_q[idx]) begin
                grant_vld = load;
                grant_idx = idx;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            assign cap[gi]      = bus.bit_valid && (bus.sel == 2'(gi));
            assign done[gi]     = cap[gi] && (cnt_q[gi] == CW'(WORD_W - 1));
            assign word_new[gi] = {shreg_q[gi], bus.ch_in[gi]};
            assign drain[gi]    = grant_vld && (grant_idx == 2'(gi));
            // A completed word is kept if its slot is free or is being
            // emptied at this same edge; otherwise it is dropped.
            assign accept[gi]   = done[gi] && (!pend_q[gi] || drain[gi]);
            assign ovf_set[gi]  = done[gi] && pend_q[gi] && !drain[gi];
        end
    endgenerate

    always_comb begin
        pend_d  = (pend_q & ~drain) | accept;
        // A new overflow event beats a simultaneous clear.
        ovf_d   = (bus.ovf_clr ? 4'b0000 : ovf_q) | ovf_set;
        valid_d = valid_q;
        data_d  = data_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
`ifdef DEMUX_DESER_PARITY_EN
        par_d   = par_q;
`endif
        if (grant_vld) begin
            valid_d = 1'b1;
            data_d  = hold_q[grant_idx];
            ch_d    = grant_idx;
            ptr_d   = grant_idx + 2'd1;
`ifdef DEMUX_DESER_PARITY_EN
            par_d   = ^hold_q[grant_idx];
`endif
        end else if (valid_q && bus.word_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                shreg_q[i] <= '0;
                cnt_q[i]   <= '0;
                hold_q[i]  <= '0;
            end
            pend_q  <= '0;
            ovf_q   <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
`ifdef DEMUX_DESER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (cap[i]) begin
                    shreg_q[i] <= word_new[i][WORD_W-2:0];
                    cnt_q[i]   <= done[i] ? '0 : cnt_q[i] + CW'(1);
                end
                if (accept[i]) begin
                    hold_q[i] <= word_new[i];
                end
            end
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
`ifdef DEMUX_DESER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.word_valid = valid_q;
    assign bus.word_data  = data_q;
    assign bus.word_ch    = ch_q;
    assign bus.overflow   = ovf_q;
`ifdef DEMUX_DESER_PARITY_EN
    assign bus.word_par   = par_q;
`endif
endmodule

// File: tb/tb_demux4_deser.sv
// ---------------------------------------------------------------------------
// tb_demux4_deser
// Directed self-checking bench for demux4_deser (WORD_W = 8). Inputs change
// just after the falling edge; outputs are checked on the falling edge.
// Define DEMUX_DESER_PARITY_EN to also exercise word_par.
// ---------------------------------------------------------------------------
module tb_demux4_deser;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    demux4_deser_if #(.WORD_W(W)) bus ();

    demux4_deser #(.WORD_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // One line per completed output transfer.
    always @(posedge clk) begin
        if (rst_n && bus.word_valid && bus.word_ready)
            $display("xfer: ch=%0d data=%h ovf=%b", bus.word_ch, bus.word_data, bus.overflow);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Bit for channel c on ch_in[c]; other lanes carry the opposite value so
    // that any leakage from them would corrupt the word.
    task automatic send_bit(input logic [1:0] c, input logic b);
        logic [3:0] v;
        v = {4{~b}};
        v[c] = b;
        bus.sel       = c;
        bus.ch_in     = v;
        bus.bit_valid = 1'b1;
        tick();
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [1:0] c, input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(c, w[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.sel        = 2'd0;
        bus.ch_in      = 4'h0;
        bus.word_ready = 1'b0;
        bus.ovf_clr    = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.word_valid !== 1'b0 || bus.word_data !== 8'h00 ||
            bus.word_ch !== 2'd0 || bus.overflow !== 4'b0000) begin
            bad++;
            $display("FAIL reset_state: got v=%b d=%h ch=%0d ovf=%b, want v=0 d=00 ch=0 ovf=0000",
                     bus.word_valid, bus.word_data, bus.word_ch, bus.overflow);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_word();
        bus.word_ready = 1'b1;
        send_bit(2'd0, 1'b1);
        send_bit(2'd0, 1'b1);
        send_bit(2'd0, 1'b1);
        do_reset();
        send_word(2'd0, 8'hA5);
        total++;
        if (bus.word_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_latency: got v=%b, want v=0 at completion edge", bus.word_valid);
        end
        tick();
        total++;
        if (bus.word_valid !== 1'b1 || bus.word_data !== 8'hA5 || bus.word_ch !== 2'd0) begin
            bad++;
            $display("FAIL mid_reset_word: got v=%b d=%h ch=%0d, want v=1 d=a5 ch=0",
                     bus.word_valid, bus.word_data, bus.word_ch);
        end
`ifdef DEMUX_DESER_PARITY_EN
        total++;
        if (bus.word_par !== 1'b0) begin
            bad++;
            $display("FAIL parity_a5: got %b, want 0", bus.word_par);
        end
`endif
        tick();
        total++;
        if (bus.word_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_drain: got v=%b, want 0", bus.word_valid);
        end
    endtask

    task automatic test_interleaved();
        logic [7:0] a;
        logic [7:0] b;
        a = 8'hF0;
        b = 8'h0F;
        bus.word_ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            send_bit(2'd1, a[i]);
            send_bit(2'd2, b[i]);
        end
        total++;
        if (bus.word_valid !== 1'b1 || bus.word_data !== 8'hF0 || bus.word_ch !== 2'd1) begin
            bad++;
            $display("FAIL interleave_first: got v=%b d=%h ch=%0d, want v=1 d=f0 ch=1",
                     bus.word_valid, bus.word_data, bus.word_ch);
        end
        tick();
        total++;
        if (bus.word_valid !== 1'b1 || bus.word_data !== 8'h0F || bus.word_ch !== 2'd2) begin
            bad++;
            $display("FAIL interleave_second: got v=%b d=%h ch=%0d, want v=1 d=0f ch=2",
                     bus.word_valid, bus.word_data, bus.word_ch);
        end
        tick();
        total++;
        if (bus.word_valid !== 1'b0) begin
            bad++;
            $display("FAIL interleave_empty: got v=%b, want 0", bus.word_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.word_ready = 1'b0;
        send_word(2'd3, 8'h3C);
        tick();
        send_word(2'd1, 8'h81);
        send_word(2'd0, 8'h7E);
        total++;
        if (bus.word_valid !== 1'b1 || bus.word_data !== 8'h3C || bus.word_ch !== 2'd3) begin
            bad++;
            $display("FAIL rr_stall_hold: got v=%b d=%h ch=%0d, want v=1 d=3c ch=3",
                     bus.word_valid, bus.word_data, bus.word_ch);
        end
        bus.word_ready = 1'b1;
        tick();
        total++;
        if (bus.word_valid !== 1'b1 || bus.word_data !== 8'h7E || bus.word_ch !== 2'd0) begin
            bad++;
            $display("FAIL rr_second: got v=%b d=%h ch=%0d, want v=1 d=7e ch=0",
                     bus.word_valid, bus.word_data, bus.word_ch);
        end
        tick();
        total++;
        if (bus.word_valid !== 1'b1 || bus.word_data !== 8'h81 || bus.word_ch !== 2'd1) begin
            bad++;
            $display("FAIL rr_third: got v=%b d=%h ch=%0d, want v=1 d=81 ch=1",
                     bus.word_valid, bus.word_data, bus.word_ch);
        end
        tick();
        total++;
        if (bus.word_valid !== 1'b0 || bus.overflow !== 4'b0000) begin
            bad++;
            $display("FAIL rr_empty: got v=%b ovf=%b, want v=0 ovf=0000", bus.word_valid, bus.overflow);
        end
    endtask

    task automatic test_overflow();
        bus.word_ready = 1'b0;
        send_word(2'd0, 8'h55);
        tick();
        send_word(2'd2, 8'h11);
        total++;
        if (bus.overflow !== 4'b0000) begin
            bad++;
            $display("FAIL ovf_none_yet: got %b, want 0000", bus.overflow);
        end
        send_word(2'd2, 8'h22);
        total++;
        if (bus.overflow !== 4'b0100) begin
            bad++;
            $display("FAIL ovf_set: got %b, want 0100", bus.overflow);
        end
        bus.word_ready = 1'b1;
        tick();
        total++;
        if (bus.word_valid !== 1'b1 || bus.word_data !== 8'h11 || bus.word_ch !== 2'd2) begin
            bad++;
            $display("FAIL ovf_kept_word: got v=%b d=%h ch=%0d, want v=1 d=11 ch=2",
                     bus.word_valid, bus.word_data, bus.word_ch);
        end
        tick();
        total++;
        if (bus.word_valid !== 1'b0 || bus.overflow !== 4'b0100) begin
            bad++;
            $display("FAIL ovf_sticky: got v=%b ovf=%b, want v=0 ovf=0100", bus.word_valid, bus.overflow);
        end
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        total++;
        if (bus.overflow !== 4'b0000) begin
            bad++;
            $display("FAIL ovf_clear: got %b, want 0000", bus.overflow);
        end
    endtask

    // Completion on a channel in the same edge its pending word is granted.
    task automatic test_drain_complete();
        logic [7:0] z;
        z = 8'h96;
        bus.word_ready = 1'b0;
        send_word(2'd1, 8'hC3);
        tick();
        send_word(2'd1, 8'h3C);
        for (int i = 7; i >= 1; i--) send_bit(2'd1, z[i]);
        bus.word_ready = 1'b1;
        send_bit(2'd1, z[0]);
        total++;
        if (bus.word_valid !== 1'b1 || bus.word_data !== 8'h3C || bus.overflow !== 4'b0000) begin
            bad++;
            $display("FAIL same_edge_drain: got v=%b d=%h ovf=%b, want v=1 d=3c ovf=0000",
                     bus.word_valid, bus.word_data, bus.overflow);
        end
        tick();
        total++;
        if (bus.word_valid !== 1'b1 || bus.word_data !== 8'h96 || bus.word_ch !== 2'd1) begin
            bad++;
            $display("FAIL same_edge_new: got v=%b d=%h ch=%0d, want v=1 d=96 ch=1",
                     bus.word_valid, bus.word_data, bus.word_ch);
        end
        tick();
        total++;
        if (bus.word_valid !== 1'b0) begin
            bad++;
            $display("FAIL same_edge_empty: got v=%b, want 0", bus.word_valid);
        end
    endtask

    task automatic test_idle();
        bus.word_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.bit_valid = 1'b0;
            bus.sel       = 2'(i);
            bus.ch_in     = 4'hF;
            tick();
            total++;
            if (bus.word_valid !== 1'b0) begin
                bad++;
                $display("FAIL idle_valid[%0d]: got v=%b, want 0", i, bus.word_valid);
            end
        end
        send_word(2'd0, 8'h5A);
        tick();
        total++;
        if (bus.word_valid !== 1'b1 || bus.word_data !== 8'h5A || bus.word_ch !== 2'd0) begin
            bad++;
            $display("FAIL idle_then_word: got v=%b d=%h ch=%0d, want v=1 d=5a ch=0",
                     bus.word_valid, bus.word_data, bus.word_ch);
        end
        tick();
    endtask

`ifdef DEMUX_DESER_PARITY_EN
    task automatic test_parity();
        bus.word_ready = 1'b1;
        send_word(2'd3, 8'h07);
        tick();
        total++;
        if (bus.word_data !== 8'h07 || bus.word_par !== 1'b1) begin
            bad++;
            $display("FAIL parity_07: got d=%h par=%b, want d=07 par=1", bus.word_data, bus.word_par);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_word();
        test_interleaved();
        test_round_robin();
        test_overflow();
        test_drain_complete();
        test_idle();
`ifdef DEMUX_DESER_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/demux4_deser.md
Name: demux4_deser

Overview:
- Downstream consumer of the 1:4 demultiplexer.
- Samples the demux outputs `out[3:0]` together with the demux select and a per-bit strobe, then deserializes each of the 4 channels independently into WORD_W-bit words.
- A round-robin arbiter drains completed words through a single valid/ready output port.
- Sits between the bit-level channel router and word-level consumers (register file / FIFO).

Parameters:
- WORD_W, 8, bits per assembled word (legal range 2..32)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- bit_valid  input  1  strobe: ch_in/sel carry a valid bit this cycle
- sel  input  2  channel index currently routed by the demux
- ch_in  input  4  demux outputs; the bit for channel sel is ch_in[sel]
- word_ready  input  1  downstream accepts word this cycle
- ovf_clr  input  1  synchronous clear of all overflow flags
- word_valid  output  1  word_data/word_ch hold a valid word
- word_data  output  WORD_W  assembled word
- word_ch  output  2  channel the word came from
- overflow  output  4  sticky per-channel overflow flags

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-word):
  - word_valid=0, word_data=0, word_ch=0, overflow=4'b0000.
  - All shift registers, bit counters and pending flags are cleared.
  - Arbiter pointer = 0.
- Bit capture, when bit_valid=1 at a rising edge:
  - Channel c = sel; bit b = ch_in[c]. Other ch_in bits are ignored.
  - shreg[c] <= {shreg[c][WORD_W-2:0], b} (MSB-first); cnt[c] increments.
  - bit_valid=0: no state change in capture logic.
- Word complete: the edge that captures bit number WORD_W of channel c:
  - cnt[c] wraps to 0.
  - The full word is copied into hold[c] and pend[c] is set, at that same edge.
  - Capture of the next word on c continues with no gap.
- Overflow: if pend[c] is already 1 and is not being drained at that same edge:
  - The new word is dropped and hold[c] is kept.
  - overflow[c] is set (sticky).
  - Simultaneous completion and drain of c: the new word is accepted and no overflow occurs.
- Output register loading:
  - Loads when word_valid=0, or when word_valid=1 and word_ready=1 (transfer).
  - Loads from the first pending channel, searching ptr, ptr+1, ... mod 4.
  - On grant of channel k: pend[k] is cleared and ptr <= k+1 mod 4.
  - No pending channel: word_valid <= 0 on transfer, otherwise it holds.
- Latency: a word completed at edge N is visible on word_valid/word_data at edge N+1 at the earliest.
- Handshake:
  - Transfer occurs when word_valid & word_ready at a rising edge.
  - word_data/word_ch are stable while word_valid=1 and word_ready=0.
  - Back-to-back transfers run at 1 word/cycle when pending words exist.
- ovf_clr=1: overflow <= 0. A new overflow event in the same cycle wins (flag is set).
- Throughput bound: at most 1 bit/cycle in, so no more than one channel completes per edge.

Optional Feature:
- Macro: DEMUX_DESER_PARITY_EN.
- Defined:
  - Adds output port `word_par` (1 bit): even parity (XOR reduction) of word_data.
  - Registered alongside word_data; reset value 0.
- Undefined:
  - Port and logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset mid-word: 3 bits into ch0, pulse rst_n=0, then send 8 bits 1,0,1,0,0,1,0,1 on ch0 with word_ready=1 -> word_data=8'hA5, word_ch=0, word_valid high one edge after the 8th bit; no stale bits appear.
- Interleaved channels: alternate ch1 bits of 8'hF0 and ch2 bits of 8'h0F each cycle (bit_valid=1) -> two words out: ch1=8'hF0 and ch2=8'h0F, in completion order.
- Round-robin under backpressure:
  - Stimulus: word_ready=0; complete ch3=8'h3C (loads output), then ch1=8'h81 and ch0=8'h7E (pending); then word_ready=1.
  - Required: outputs in the order ch3, ch0, ch1 (ptr=0 after reset grants ch3, ptr->0, then ch0, then ch1).
- Overflow: word_ready=0, output occupied by ch0; ch2 completes 8'h11 then 8'h22 -> overflow=4'b0100; after release, ch2 word delivered is 8'h11; ovf_clr=1 -> overflow=0000.
- Idle/masking: bit_valid=0 for 20 cycles with toggling sel/ch_in=4'hF -> no counter change, word_valid stays 0.
- Parity build (DEMUX_DESER_PARITY_EN): word 8'hA5 -> word_par=0; word 8'h07 -> word_par=1.
